uart_rx_mmio: RTL and testbench
===============================

Name: uart_rx_mmio

Overview:
- MMIO-mapped UART receiver; the receive-side counterpart of the existing LED/UART transmit peripheral.
- Deserialises 8N1 frames from an asynchronous serial pin into a small RX FIFO.
- CPU reads the FIFO and status over the standard MMIO slave interface.
- Raises a level interrupt toward irq_router when data is pending.

Parameters:
- BAUD_DIV, 434, reset value of the clocks-per-bit divisor (50 MHz / 115200).
- FIFO_DEPTH, 8, RX FIFO entries; must be a power of two, at least 2.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- mmio_req  input  1  access request, one-cycle pulse per access
- mmio_we  input  1  1 = write, 0 = read
- mmio_addr  input  32  byte address; only [3:2] decoded
- mmio_wdata  input  32  write data
- mmio_rdata  output  32  read data, valid while mmio_ready = 1
- mmio_ready  output  1  one-cycle completion pulse
- uart_rx  input  1  serial line, idle high, asynchronous to clk
- rx_irq  output  1  level interrupt, registered

Behaviour:
- Reset values:
  - mmio_rdata = 0, mmio_ready = 0, rx_irq = 0.
  - FIFO empty; sticky flags cleared.
  - CTRL = 0x1 (enable = 1, irq_en = 0); BAUD = BAUD_DIV.
  - Synchroniser flops = 1; FSM in IDLE.
- Input sync: uart_rx passes through a 2-flop synchroniser; all FSM decisions use the synchronised value.
- MMIO handshake:
  - mmio_ready asserts exactly 1 cycle after mmio_req (fixed latency 1), with mmio_rdata registered on the same edge.
  - mmio_rdata = 0 on writes and when not ready.
  - No back-pressure; a new req may arrive in the cycle after ready.
- Register map (offset = addr[3:2]*4):
  - 0x0 RXDATA (RO): [7:0] head byte, [8] valid. A read with the FIFO non-empty pops one entry. A read with the FIFO empty returns 0 and pops nothing.
  - 0x4 STATUS:
    - [0] not_empty, [1] full (RO).
    - [2] overrun, [3] frame_err, [4] parity_err: sticky, write-1-to-clear.
    - [11:8] count (RO; bits of count above 3 are truncated if FIFO_DEPTH > 15).
  - 0x8 CTRL (RW): [0] enable, [1] irq_en.
  - 0xC BAUD (RW): [15:0] divisor. Values below 4 are clamped to 4 internally. The divisor is latched at each start-bit detect, so a write mid-frame only affects the next frame.
- Receive FSM states: IDLE, START, DATA, PARITY (macro only), STOP, WAIT_IDLE.
  - IDLE: when enable = 1 and a synchronised falling edge is seen, latch the divisor, load cnt = div/2 - 1, go to START.
  - START: at cnt = 0, sample the line. If high, it was a glitch: return to IDLE with no flag. If low, reload cnt = div-1 and go to DATA.
  - DATA: sample at each cnt = 0, LSB first. After the 8th bit, go to STOP (or PARITY).
  - STOP: sample at cnt = 0.
    - Line = 1: push the byte; go to IDLE.
    - Line = 0: set frame_err, discard the byte, go to WAIT_IDLE.
  - WAIT_IDLE: stay until the line has been high for one full bit time, then go to IDLE.
- enable cleared mid-frame: FSM returns to IDLE next cycle; the partial byte is discarded, no flag.
- FIFO full at push: byte dropped, overrun set, contents unchanged.
- Push and pop in the same cycle:
  - Non-empty FIFO: both occur, count unchanged.
  - Empty FIFO: the pop returns 0 and the pushed byte is retained.
- Pointer wrap: log2(FIFO_DEPTH)-bit pointers plus a count register.
- Write-1-to-clear on the same cycle as a flag set: the set wins.
- rx_irq is registered as irq_en & not_empty, so it lags a push or pop by 1 cycle.
- Reset asserted mid-frame or mid-access: immediate return to reset values; the FIFO is flushed.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - CTRL[2] = parity_en, CTRL[3] = odd (both reset 0).
  - When parity_en = 1, the frame carries a ninth bit handled in the PARITY state.
  - On parity mismatch: set parity_err; the byte is still pushed, with RXDATA[9] = 1 for that entry.
- Undefined:
  - No PARITY state; CTRL[3:2] read as 0.
  - STATUS[4] and RXDATA[9] always read 0.

Decomposition:
- Shared package/header holds:
  - register offsets (UART_RX_DATA/STATUS/CTRL/BAUD);
  - STATUS/CTRL bit indices;
  - FSM state encodings.
- One natural sub-module: uart_rx_fifo, a synchronous FIFO with push/pop/full/empty/count, parameterised by depth and width.

Test Plan:
- Reset, then BAUD = 16; send 0xA5 8N1 -> STATUS[0] = 1, count = 1; read 0x0 -> 0x1A5; next read -> 0x000.
- Low pulse of 4 cycles on an idle line (BAUD = 16) -> no push, no flags, FSM back in IDLE.
- Send 9 bytes 0x00..0x08 with FIFO_DEPTH = 8, no reads -> full = 1, overrun = 1; reads return 0x100..0x107; write 0x4 to STATUS -> overrun = 0.
- Frame 0x55 with stop bit = 0 -> frame_err = 1, count = 0; the following good frame 0x3C is received correctly.
- irq_en = 1; receive 0x7E -> rx_irq high 1 cycle after the push; read RXDATA -> rx_irq low 1 cycle after the pop.
- With UART_RX_PARITY_EN, parity_en = 1, even parity: send 0x01 with parity bit 0 -> parity_err = 1, RXDATA = 0x301.

Source files
------------

// File: rtl/uart_rx_mmio_pkg.sv
// rtl/uart_rx_mmio_pkg.sv - shared constants, state encoding and helpers for uart_rx_mmio
//
// Contents:
//   UART_RX_DATA/STATUS/CTRL/BAUD  byte offsets of the four registers
//   ST_* / CTRL_* / RXD_*           bit positions inside STATUS, CTRL and RXDATA
//   rx_state_e                      receive FSM state encoding
//   clamp_div()                     lower bound applied to the programmed divisor
package uart_rx_mmio_pkg;

  localparam logic [3:0] UART_RX_DATA   = 4'h0;
  localparam logic [3:0] UART_RX_STATUS = 4'h4;
  localparam logic [3:0] UART_RX_CTRL   = 4'h8;
  localparam logic [3:0] UART_RX_BAUD   = 4'hC;

  localparam int ST_NOT_EMPTY  = 0;
  localparam int ST_FULL       = 1;
  localparam int ST_OVERRUN    = 2;
  localparam int ST_FRAME_ERR  = 3;
  localparam int ST_PARITY_ERR = 4;

  localparam int CTRL_ENABLE    = 0;
  localparam int CTRL_IRQ_EN    = 1;
  localparam int CTRL_PARITY_EN = 2;
  localparam int CTRL_ODD       = 3;

  localparam int RXD_VALID   = 8;
  localparam int RXD_PAR_ERR = 9;

  localparam logic [15:0] MIN_DIV = 16'd4;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_PARITY    = 3'd3,
    RX_STOP      = 3'd4,
    RX_WAIT_IDLE = 3'd5
  } rx_state_e;

  // Very small divisors leave no room for a mid-bit sample point.
  function automatic logic [15:0] clamp_div(input logic [15:0] d);
    return (d < MIN_DIV) ? MIN_DIV : d;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - synchronous FIFO with push/pop/full/empty/count
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset (flushes the FIFO)
//   push, din           write request and data; ignored while full
//   pop                 read request; ignored while empty
//   dout                head entry (meaningful while !empty)
//   full, empty, count  occupancy
module uart_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign count   = cnt;
  assign dout    = mem[rd_ptr];
  // A pop on an empty FIFO is a no-op, so a same-cycle push is simply kept.
  assign do_pop  = pop & ~empty;
  assign do_push = push & ~full;

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers are exactly log2(DEPTH) wide, so they wrap on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_mmio.sv
// rtl/uart_rx_mmio.sv - MMIO-mapped 8N1 UART receiver with RX FIFO and level interrupt
//
// Optional feature: define UART_RX_PARITY_EN to add a ninth (parity) bit per frame.
//
// Ports:
//   clk, rst_n              system clock, asynchronous active-low reset
//   mmio_req, mmio_we       one-cycle access request, 1 = write
//   mmio_addr, mmio_wdata   byte address (only [3:2] decoded), write data
//   mmio_rdata, mmio_ready  read data and completion pulse, one cycle after mmio_req
//   uart_rx                 serial input, idle high, asynchronous to clk
//   rx_irq                  registered irq_en & not_empty
module uart_rx_mmio
  import uart_rx_mmio_pkg::*;
#(
  parameter int BAUD_DIV   = 434,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mmio_req,
  input  logic        mmio_we,
  input  logic [31:0] mmio_addr,
  input  logic [31:0] mmio_wdata,
  output logic [31:0] mmio_rdata,
  output logic        mmio_ready,
  input  logic        uart_rx,
  output logic        rx_irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  // Line synchroniser plus one extra stage for falling-edge detection.
  logic rx_s1, rx_s2, rx_prev;
  logic rx_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= uart_rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  assign rx_fall = rx_prev & ~rx_s2;

  // Register decode.
  logic [3:0] reg_off;
  logic       wr_en, rd_en;
  logic       wr_status, wr_ctrl, wr_baud, rd_data;
  logic       unused_bits;

  assign reg_off   = {mmio_addr[3:2], 2'b00};
  assign wr_en     = mmio_req & mmio_we;
  assign rd_en     = mmio_req & ~mmio_we;
  assign wr_status = wr_en & (reg_off == UART_RX_STATUS);
  assign wr_ctrl   = wr_en & (reg_off == UART_RX_CTRL);
  assign wr_baud   = wr_en & (reg_off == UART_RX_BAUD);
  assign rd_data   = rd_en & (reg_off == UART_RX_DATA);
  assign unused_bits = ^{mmio_addr[31:4], mmio_addr[1:0], mmio_wdata[31:16]};

  // Control registers and sticky flags.
  logic        ctrl_en, ctrl_irq_en;
  logic [15:0] baud_reg;
  logic        st_overrun, st_frame_err;
`ifdef UART_RX_PARITY_EN
  logic        ctrl_par_en, ctrl_odd;
  logic        st_parity_err;
`endif

  // FIFO interface; entries are {parity_error, byte}.
  logic          push, set_frame, set_par;
  logic [8:0]    fifo_dout;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [3:0]    count_field;

  // Receive FSM state and datapath.
  rx_state_e   state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [15:0] div_q, div_n;
  logic [15:0] div_in;
  logic [2:0]  bit_idx, bit_idx_n;
  logic [7:0]  shreg, shreg_n;
  logic        par_bad, par_bad_n;
  logic        tick;

  assign div_in = clamp_div(baud_reg);
  assign tick   = (cnt == 16'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RX_IDLE;
      cnt     <= '0;
      div_q   <= MIN_DIV;
      bit_idx <= '0;
      shreg   <= '0;
      par_bad <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      div_q   <= div_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
      par_bad <= par_bad_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    div_n     = div_q;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    par_bad_n = par_bad;
    push      = 1'b0;
    set_frame = 1'b0;
    set_par   = 1'b0;
    if (!ctrl_en) begin
      // Dropping enable abandons any partial frame silently.
      state_n = RX_IDLE;
    end else begin
      case (state)
        RX_IDLE: begin
          if (rx_fall) begin
            // Divisor is frozen per frame; aim the first sample at mid start bit.
            div_n   = div_in;
            cnt_n   = (div_in >> 1) - 16'd1;
            state_n = RX_START;
          end
        end
        RX_START: begin
          if (!tick) begin
            cnt_n = cnt - 16'd1;
          end else if (rx_s2) begin
            state_n = RX_IDLE;
          end else begin
            cnt_n     = div_q - 16'd1;
            bit_idx_n = 3'd0;
            par_bad_n = 1'b0;
            state_n   = RX_DATA;
          end
        end
        RX_DATA: begin
          if (!tick) begin
            cnt_n = cnt - 16'd1;
          end else begin
            shreg_n = {rx_s2, shreg[7:1]};
            cnt_n   = div_q - 16'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_n = ctrl_par_en ? RX_PARITY : RX_STOP;
`else
              state_n = RX_STOP;
`endif
            end else begin
              bit_idx_n = bit_idx + 3'd1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        RX_PARITY: begin
          if (!tick) begin
            cnt_n = cnt - 16'd1;
          end else begin
            // Even mode wants an even number of ones over data+parity.
            if (^shreg ^ rx_s2 ^ ctrl_odd) begin
              par_bad_n = 1'b1;
              set_par   = 1'b1;
            end
            cnt_n   = div_q - 16'd1;
            state_n = RX_STOP;
          end
        end
`endif
        RX_STOP: begin
          if (!tick) begin
            cnt_n = cnt - 16'd1;
          end else if (rx_s2) begin
            push    = 1'b1;
            state_n = RX_IDLE;
          end else begin
            set_frame = 1'b1;
            cnt_n     = div_q - 16'd1;
            state_n   = RX_WAIT_IDLE;
          end
        end
        RX_WAIT_IDLE: begin
          // Need one uninterrupted bit time of idle before hunting again.
          if (!rx_s2)     cnt_n   = div_q - 16'd1;
          else if (tick)  state_n = RX_IDLE;
          else            cnt_n   = cnt - 16'd1;
        end
        default: state_n = RX_IDLE;
      endcase
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (9)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   ({par_bad, shreg}),
    .pop   (rd_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign count_field = 4'(fifo_count);

  // Sticky flags: a set in the same cycle as a write-1-to-clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_en       <= 1'b1;
      ctrl_irq_en   <= 1'b0;
      baud_reg      <= 16'(BAUD_DIV);
      st_overrun    <= 1'b0;
      st_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      ctrl_par_en   <= 1'b0;
      ctrl_odd      <= 1'b0;
      st_parity_err <= 1'b0;
`endif
    end else begin
      if (wr_ctrl) begin
        ctrl_en     <= mmio_wdata[CTRL_ENABLE];
        ctrl_irq_en <= mmio_wdata[CTRL_IRQ_EN];
`ifdef UART_RX_PARITY_EN
        ctrl_par_en <= mmio_wdata[CTRL_PARITY_EN];
        ctrl_odd    <= mmio_wdata[CTRL_ODD];
`endif
      end
      if (wr_baud) baud_reg <= mmio_wdata[15:0];
      st_overrun   <= (st_overrun & ~(wr_status & mmio_wdata[ST_OVERRUN]))
                      | (push & fifo_full);
      st_frame_err <= (st_frame_err & ~(wr_status & mmio_wdata[ST_FRAME_ERR]))
                      | set_frame;
`ifdef UART_RX_PARITY_EN
      st_parity_err <= (st_parity_err & ~(wr_status & mmio_wdata[ST_PARITY_ERR]))
                       | set_par;
`endif
    end
  end

  // Read mux, evaluated in the request cycle (before any pop takes effect).
  logic [31:0] rd_val;

  always_comb begin
    rd_val = '0;
    case (reg_off)
      UART_RX_DATA: begin
        if (!fifo_empty) begin
          rd_val[7:0]         = fifo_dout[7:0];
          rd_val[RXD_VALID]   = 1'b1;
          rd_val[RXD_PAR_ERR] = fifo_dout[8];
        end
      end
      UART_RX_STATUS: begin
        rd_val[ST_NOT_EMPTY] = ~fifo_empty;
        rd_val[ST_FULL]      = fifo_full;
        rd_val[ST_OVERRUN]   = st_overrun;
        rd_val[ST_FRAME_ERR] = st_frame_err;
`ifdef UART_RX_PARITY_EN
        rd_val[ST_PARITY_ERR] = st_parity_err;
`endif
        rd_val[11:8] = count_field;
      end
      UART_RX_CTRL: begin
        rd_val[CTRL_ENABLE] = ctrl_en;
        rd_val[CTRL_IRQ_EN] = ctrl_irq_en;
`ifdef UART_RX_PARITY_EN
        rd_val[CTRL_PARITY_EN] = ctrl_par_en;
        rd_val[CTRL_ODD]       = ctrl_odd;
`endif
      end
      UART_RX_BAUD: rd_val[15:0] = baud_reg;
      default:      rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mmio_ready <= 1'b0;
      mmio_rdata <= '0;
      rx_irq     <= 1'b0;
    end else begin
      mmio_ready <= mmio_req;
      mmio_rdata <= rd_en ? rd_val : 32'h0;
      rx_irq     <= ctrl_irq_en & ~fifo_empty;
    end
  end

endmodule

// File: tb/tb_uart_rx_mmio.sv
// tb/tb_uart_rx_mmio.sv - scoreboard bench for uart_rx_mmio
`timescale 1ns/1ps
module tb_uart_rx_mmio;

  localparam int DEPTH = 8;
`ifdef UART_RX_PARITY_EN
  localparam logic [31:0] CTRL_MASK = 32'hF;
`else
  localparam logic [31:0] CTRL_MASK = 32'h3;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mmio_req = 1'b0;
  logic        mmio_we = 1'b0;
  logic [31:0] mmio_addr = '0;
  logic [31:0] mmio_wdata = '0;
  logic [31:0] mmio_rdata;
  logic        mmio_ready;
  logic        uart_rx = 1'b1;
  logic        rx_irq;

  always #5 clk = ~clk;

  uart_rx_mmio #(.BAUD_DIV(434), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .mmio_req(mmio_req), .mmio_we(mmio_we),
    .mmio_addr(mmio_addr), .mmio_wdata(mmio_wdata), .mmio_rdata(mmio_rdata),
    .mmio_ready(mmio_ready), .uart_rx(uart_rx), .rx_irq(rx_irq)
  );

  typedef struct { string name; logic [31:0] exp; } sb_item_t;
  sb_item_t sb_q[$];
  sb_item_t mon_it;
  int n_checks = 0;
  int n_pass = 0;

  // Reference model: what the CPU should observe.
  logic [9:0]  m_fifo[$];
  bit          m_over, m_frame, m_par;
  logic [31:0] m_ctrl;
  logic [15:0] m_baud;
  logic [15:0] btab[6] = '{16'd2, 16'd4, 16'd5, 16'd8, 16'd16, 16'd23};

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
  endtask

  function automatic void model_reset();
    m_fifo.delete();
    m_over = 0; m_frame = 0; m_par = 0;
    m_ctrl = 32'h1;
    m_baud = 16'd434;
  endfunction

  function automatic int bit_time();
    return (m_baud < 16'd4) ? 4 : int'(m_baud);
  endfunction

  function automatic logic [31:0] m_status();
    return {20'h0, 4'(m_fifo.size()), 3'b0, m_par, m_frame, m_over,
            (m_fifo.size() == DEPTH), (m_fifo.size() != 0)};
  endfunction

  function automatic logic [31:0] m_rxdata();
    logic [9:0] e;
    if (m_fifo.size() == 0) return 32'h0;
    e = m_fifo.pop_front();
    return {22'h0, e};
  endfunction

  function automatic void m_frame_in(input logic [7:0] d, input bit stop, input bit pbad);
    if (pbad) m_par = 1;
    if (!stop) m_frame = 1;
    else if (m_fifo.size() == DEPTH) m_over = 1;
    else m_fifo.push_back({pbad, 1'b1, d});
  endfunction

  // Monitor: every completion is matched against the oldest expectation.
  always @(negedge clk) begin
    if (mmio_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_ready", 32'h1, 32'h0);
      end else begin
        mon_it = sb_q.pop_front();
        check(mon_it.name, mmio_rdata, mon_it.exp);
      end
    end else if (rst_n) begin
      check("rdata_idle", mmio_rdata, 32'h0);
    end
  end

  task automatic mmio(input bit we, input logic [3:0] off, input logic [31:0] wd,
                      input logic [31:0] exp, input string nm);
    logic [31:0] a;
    sb_item_t it;
    a = $urandom;
    a[3:2] = off[3:2];
    mmio_req = 1'b1; mmio_we = we; mmio_addr = a; mmio_wdata = wd;
    it.name = nm;
    it.exp  = we ? 32'h0 : exp;
    sb_q.push_back(it);
    @(negedge clk);
    mmio_req = 1'b0; mmio_we = 1'b0; mmio_wdata = $urandom;
  endtask

  task automatic wr(input logic [3:0] off, input logic [31:0] d);
    case (off)
      4'h4: begin
        if (d[2]) m_over = 0;
        if (d[3]) m_frame = 0;
        if (d[4]) m_par = 0;
      end
      4'h8: m_ctrl = d & CTRL_MASK;
      4'hC: m_baud = d[15:0];
      default: ;
    endcase
    mmio(1'b1, off, d, 32'h0, "write");
  endtask

  task automatic rd(input logic [3:0] off, input string nm);
    logic [31:0] e;
    case (off)
      4'h0: e = m_rxdata();
      4'h4: e = m_status();
      4'h8: e = m_ctrl;
      default: e = {16'h0, m_baud};
    endcase
    mmio(1'b0, off, $urandom, e, nm);
  endtask

  task automatic drive_bit(input logic v, input int n);
    uart_rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop, input bit has_par,
                            input bit par, input bit upd);
    int bt;
    bt = bit_time();
    drive_bit(1'b0, bt);
    for (int i = 0; i < 8; i++) drive_bit(d[i], bt);
    if (has_par) drive_bit(par, bt);
    drive_bit(stop, bt);
    drive_bit(1'b1, 2 * bt + 4);
    if (upd) m_frame_in(d, stop, has_par && ((^d ^ par) != m_ctrl[3]));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_ready", {31'h0, mmio_ready}, 32'h0);
    check("rst_rdata", mmio_rdata, 32'h0);
    check("rst_irq", {31'h0, rx_irq}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    rd(4'h8, "rst_ctrl");
    rd(4'hC, "rst_baud");
    rd(4'h4, "rst_status");
    rd(4'h0, "rst_rxdata_empty");

    // Basic frame.
    wr(4'hC, 32'd16);
    send_frame(8'hA5, 1, 0, 0, 1);
    rd(4'h4, "a5_status");
    rd(4'h0, "a5_rxdata");
    rd(4'h0, "a5_rxdata_empty");

    // Start-bit glitch must be rejected silently.
    drive_bit(1'b0, 4);
    drive_bit(1'b1, 40);
    rd(4'h4, "glitch_status");
    send_frame(8'h5A, 1, 0, 0, 1);
    rd(4'h0, "after_glitch_rxdata");

    // Overrun.
    for (int i = 0; i < 9; i++) send_frame(8'(i), 1, 0, 0, 1);
    rd(4'h4, "ovr_status");
    for (int i = 0; i < 9; i++) rd(4'h0, "ovr_rxdata");
    wr(4'h4, 32'h4);
    rd(4'h4, "ovr_cleared");

    // Framing error then recovery.
    send_frame(8'h55, 0, 0, 0, 1);
    rd(4'h4, "ferr_status");
    send_frame(8'h3C, 1, 0, 0, 1);
    rd(4'h0, "ferr_next_rxdata");
    wr(4'h4, 32'h8);
    rd(4'h4, "ferr_cleared");

    // Interrupt.
    wr(4'h8, 32'h3);
    check("irq_idle", {31'h0, rx_irq}, 32'h0);
    send_frame(8'h7E, 1, 0, 0, 1);
    check("irq_set", {31'h0, rx_irq}, 32'h1);
    rd(4'h0, "irq_rxdata");
    check("irq_lag", {31'h0, rx_irq}, 32'h1);
    @(negedge clk);
    check("irq_clr", {31'h0, rx_irq}, 32'h0);
    wr(4'h8, 32'h1);

    // Enable dropped mid-frame discards the partial byte.
    fork
      send_frame(8'h00, 1, 0, 0, 0);
      begin
        repeat (4 * bit_time()) @(negedge clk);
        wr(4'h8, 32'h0);
      end
    join
    wr(4'h8, 32'h1);
    rd(4'h4, "disable_status");
    send_frame(8'h81, 1, 0, 0, 1);
    rd(4'h0, "reenable_rxdata");

    // Divisor clamp.
    wr(4'hC, 32'd2);
    rd(4'hC, "baud_raw");
    send_frame(8'hC3, 1, 0, 0, 1);
    rd(4'h0, "clamp_rxdata");

    // Randomised traffic.
    for (int it = 0; it < 60; it++) begin
      int act;
      act = $urandom_range(0, 9);
      if (act <= 4)      send_frame(8'($urandom), ($urandom_range(0, 9) != 0), 0, 0, 1);
      else if (act <= 6) rd(4'h0, "rnd_rxdata");
      else if (act == 7) rd(4'h4, "rnd_status");
      else if (act == 8) wr(4'hC, {16'h0, btab[$urandom_range(0, 5)]});
      else               wr(4'h4, $urandom);
    end
    for (int i = 0; i < DEPTH + 1; i++) rd(4'h0, "drain_rxdata");
    wr(4'h4, 32'h1C);
    rd(4'h4, "drain_status");

`ifdef UART_RX_PARITY_EN
    wr(4'hC, 32'd16);
    wr(4'h8, 32'h5);
    send_frame(8'h01, 1, 1, 0, 1);
    rd(4'h4, "par_status");
    rd(4'h0, "par_rxdata");
    wr(4'h8, 32'hD);
    send_frame(8'h07, 1, 1, 0, 1);
    rd(4'h0, "par_odd_rxdata");
    wr(4'h4, 32'h10);
    rd(4'h4, "par_cleared");
    wr(4'h8, 32'h1);
`endif

    // Reset mid-frame flushes everything.
    wr(4'hC, 32'd16);
    wr(4'h8, 32'h3);
    send_frame(8'h11, 1, 0, 0, 1);
    check("irq_pre_reset", {31'h0, rx_irq}, 32'h1);
    fork
      send_frame(8'hFF, 1, 0, 0, 0);
      begin
        repeat (3 * bit_time()) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_ready", {31'h0, mmio_ready}, 32'h0);
        check("midrst_irq", {31'h0, rx_irq}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
      end
    join
    rd(4'h4, "post_rst_status");
    rd(4'h8, "post_rst_ctrl");
    rd(4'hC, "post_rst_baud");
    wr(4'hC, 32'd16);
    send_frame(8'h99, 1, 0, 0, 1);
    rd(4'h0, "post_rst_rxdata");

    repeat (5) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
